// File: rtl/ps2_keys_pkg.sv
// PS/2 set-2 scan codes used by the operand entry block, and the
// operand-entry FSM state encoding.
package ps2_keys_pkg;

    // Digit make codes, main keyboard row 0..9
    localparam logic [7:0] KEY_0     = 8'h45;
    localparam logic [7:0] KEY_1     = 8'h16;
    localparam logic [7:0] KEY_2     = 8'h1E;
    localparam logic [7:0] KEY_3     = 8'h26;
    localparam logic [7:0] KEY_4     = 8'h25;
    localparam logic [7:0] KEY_5     = 8'h2E;
    localparam logic [7:0] KEY_6     = 8'h36;
    localparam logic [7:0] KEY_7     = 8'h3D;
    localparam logic [7:0] KEY_8     = 8'h3E;
    localparam logic [7:0] KEY_9     = 8'h46;

    // Prefix and editing codes
    localparam logic [7:0] KEY_BREAK = 8'hF0;
    localparam logic [7:0] KEY_EXT   = 8'hE0;
    localparam logic [7:0] KEY_ENTER = 8'h5A;
    localparam logic [7:0] KEY_ESC   = 8'h76;
    localparam logic [7:0] KEY_BKSP  = 8'h66;
    localparam logic [7:0] KEY_MINUS = 8'h4E;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ENTRY = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/ps2_digit_decode.sv
// Combinational map from a scan byte to a decimal digit.
module ps2_digit_decode
    import ps2_keys_pkg::*;
(
    input  logic [7:0] code,
    output logic       is_digit,
    output logic [3:0] value
);

    // Table lookup; anything that is not a digit key reports is_digit=0.
    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        is_digit = 1'b1;
        value    = 4'd0;
        case (code)
            KEY_0:   value = 4'd0;
            KEY_1:   value = 4'd1;
            KEY_2:   value = 4'd2;
            KEY_3:   value = 4'd3;
            KEY_4:   value = 4'd4;
            KEY_5:   value = 4'd5;
            KEY_6:   value = 4'd6;
            KEY_7:   value = 4'd7;
            KEY_8:   value = 4'd8;
            KEY_9:   value = 4'd9;
            default: is_digit = 1'b0;
        endcase
    end

endmodule

// File: rtl/ps2_operand_entry.sv
// Decimal operand entry from a PS/2 scan-code stream. Digits accumulate
// into a WIDTH-bit magnitude; minus, backspace, escape and enter edit or
// commit it. The committed (sign-applied) value is offered on a
// valid/ready handshake. While entering, number shows the live magnitude.
module ps2_operand_entry
    import ps2_keys_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MAX_DIGITS  = 9,
    parameter bit SIGNED_MODE = 1'b1,
    parameter bit ENABLE_BKSP = 1'b1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              code_valid,
    input  logic [7:0]                        code,
    input  logic                              enable,
    input  logic                              op_request,
    input  logic                              out_ready,
    output logic                              out_valid,
    output logic [WIDTH-1:0]                  number,
    output logic [$clog2(MAX_DIGITS+1)-1:0]   digit_count,
    output logic                              overflow,
    output logic                              mem_wr,
    output logic                              busy
);

    localparam int CW = $clog2(MAX_DIGITS + 1);
    localparam int AW = WIDTH + 4;

    // Largest magnitude accepted: a signed operand may reach 2^(WIDTH-1)
    // so that the most negative value can be entered.
    localparam logic [AW-1:0] LIMIT = SIGNED_MODE ? (AW'(1) << (WIDTH - 1))
                                                  : ((AW'(1) << WIDTH) - AW'(1));

    state_t           state;
    state_t           state_nxt;
    logic             break_pending;
    logic             key_valid;
    logic [WIDTH-1:0] acc;
    logic             sign;
    logic             is_digit;
    logic [3:0]       digit_val;
    logic [AW-1:0]    acc_ext;
    logic [AW-1:0]    acc_x10_d;
    logic [WIDTH-1:0] acc_div10;
    logic [WIDTH-1:0] commit_val;
    logic             start_entry;

    ps2_digit_decode u_digit_decode (
        .code     (code),
        .is_digit (is_digit),
        .value    (digit_val)
    );

    // Prefilter: a byte counts as a key only if it is not a prefix and is
    // not the byte that follows a break prefix.
    always_comb begin
        key_valid = code_valid && enable && !break_pending &&
                    (code != KEY_BREAK) && (code != KEY_EXT);
    end

    // Arithmetic for the accumulator: acc*10+d by shifts, acc/10 by a
    // constant divider, and two's-complement negation for commit.
    always_comb begin
        acc_ext    = AW'(acc);
        acc_x10_d  = (acc_ext << 3) + (acc_ext << 1) + AW'(digit_val);
        acc_div10  = acc / WIDTH'(10);
        commit_val = sign ? (~acc + WIDTH'(1)) : acc;
    end

    assign start_entry = (state == ST_IDLE) && op_request;
    assign out_valid   = (state == ST_DONE);
    assign busy        = (state != ST_IDLE);

    // FSM state register.
    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; a handshake in DONE wins over a coincident op_request.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (op_request) state_nxt = ST_ENTRY;
            ST_ENTRY: if (key_valid && code == KEY_ENTER) state_nxt = ST_DONE;
            ST_DONE:  if (out_ready) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Break-prefix tracking: F0 arms it, the next byte only disarms it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            break_pending <= 1'b0;
        end else if (code_valid && enable) begin
            break_pending <= break_pending ? 1'b0 : (code == KEY_BREAK);
        end
    end

    // Accumulator, sign, digit count, overflow flag and the number register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc         <= '0;
            sign        <= 1'b0;
            digit_count <= '0;
            overflow    <= 1'b0;
            number      <= '0;
            mem_wr      <= 1'b0;
        end else begin
            mem_wr <= start_entry;
            if (start_entry) begin
                acc         <= '0;
                sign        <= 1'b0;
                digit_count <= '0;
                overflow    <= 1'b0;
                number      <= '0;
            end else if (state == ST_ENTRY && key_valid) begin
                if (is_digit) begin
                    if (acc_x10_d > LIMIT) begin
                        overflow <= 1'b1;
                    end else if (digit_count == CW'(MAX_DIGITS)) begin
                        // full: the digit is dropped without flagging
                    end else if (acc == '0 && digit_val == 4'd0) begin
                        // leading zero: nothing to record
                    end else begin
                        acc         <= acc_x10_d[WIDTH-1:0];
                        number      <= acc_x10_d[WIDTH-1:0];
                        digit_count <= digit_count + CW'(1);
                    end
                end else begin
                    case (code)
                        KEY_MINUS: if (SIGNED_MODE) sign <= ~sign;
                        KEY_BKSP: begin
                            if (ENABLE_BKSP) begin
                                acc      <= acc_div10;
                                number   <= acc_div10;
                                overflow <= 1'b0;
                                if (digit_count != '0) digit_count <= digit_count - CW'(1);
                            end
                        end
                        KEY_ESC: begin
                            acc         <= '0;
                            sign        <= 1'b0;
                            digit_count <= '0;
                            overflow    <= 1'b0;
                            number      <= '0;
                        end
                        KEY_ENTER: number <= commit_val;
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule
